// File: rtl/task_1_counter.sv
// Loadable up-counter: asynchronous clear, synchronous load with priority over
// count enable, and modulo-2**WIDTH increment. The count is driven straight from the state register.
module task_1_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out
);

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_nxt_s;

    // Next-count selection: load wins over enable, otherwise hold.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = cnt_in;
        end else if (enab) begin
            cnt_nxt_s = cnt_r + WIDTH'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt_out = cnt_r;

endmodule

// File: tb/tb_task_1_counter.sv
// Directed bench for task_1_counter: stimulus pushes hand-computed expected
// counts into a queue, and an independent monitor pops one and compares it on each sample point.
module tb_task_1_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic       enab;
    logic [3:0] cnt_in;
    logic [3:0] cnt_out;

    logic [3:0] exp_q[$];
    int         n_cmp;
    int         n_err;
    event       sample_ev;

    task_1_counter #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .enab    (enab),
        .cnt_in  (cnt_in),
        .cnt_out (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected value is consumed per sample point.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (cnt_out !== e) begin
                    n_err++;
                    $display("FAIL cnt_out: got %0d expected %0d at %0t", cnt_out, e, $time);
                end
            end
        end
    end

    // Drive inputs, take one rising edge, queue the value expected after it.
    task automatic step(input logic l, input logic e, input logic [3:0] d, input logic [3:0] exp_v);
        load   = l;
        enab   = e;
        cnt_in = d;
        @(posedge clk);
        exp_q.push_back(exp_v);
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        load   = 1'b0;
        enab   = 1'b1;
        cnt_in = 4'd0;

        // Reset held with enable high: count stays at zero.
        #2;
        exp_q.push_back(4'd0);
        -> sample_ev;
        step(1'b0, 1'b1, 4'd0, 4'd0);
        step(1'b0, 1'b1, 4'd0, 4'd0);
        rst = 1'b0;
        step(1'b0, 1'b1, 4'd0, 4'd1);
        step(1'b0, 1'b1, 4'd0, 4'd2);
        step(1'b0, 1'b1, 4'd0, 4'd3);

        // Load 13 with enable high, then count through the wrap.
        step(1'b1, 1'b1, 4'd13, 4'd13);
        step(1'b0, 1'b1, 4'd0,  4'd14);
        step(1'b0, 1'b1, 4'd0,  4'd15);
        step(1'b0, 1'b1, 4'd0,  4'd0);
        step(1'b0, 1'b1, 4'd0,  4'd1);

        // Load without enable, then hold while cnt_in toggles.
        step(1'b1, 1'b0, 4'd15, 4'd15);
        step(1'b0, 1'b0, 4'd5,  4'd15);
        step(1'b0, 1'b0, 4'd10, 4'd15);
        step(1'b0, 1'b0, 4'd0,  4'd15);
        step(1'b0, 1'b0, 4'd3,  4'd15);
        step(1'b0, 1'b0, 4'd12, 4'd15);

        // Load held on consecutive edges: reloads, no increments.
        step(1'b1, 1'b0, 4'd8,  4'd8);
        step(1'b1, 1'b1, 4'd13, 4'd13);
        step(1'b1, 1'b1, 4'd15, 4'd15);
        step(1'b0, 1'b1, 4'd7,  4'd0);

        // Count to 6, then clear mid-cycle without waiting for an edge.
        step(1'b1, 1'b0, 4'd4, 4'd4);
        step(1'b0, 1'b1, 4'd0, 4'd5);
        step(1'b0, 1'b1, 4'd0, 4'd6);
        rst = 1'b1;
        #1;
        exp_q.push_back(4'd0);
        -> sample_ev;
        step(1'b1, 1'b1, 4'd9, 4'd0);
        step(1'b0, 1'b1, 4'd9, 4'd0);
        rst = 1'b0;
        step(1'b0, 1'b1, 4'd0, 4'd1);
        step(1'b0, 1'b1, 4'd0, 4'd2);

        // Bounded drain of the scoreboard.
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
